// File: rtl/ddr_rd_burst_sched.sv
`timescale 1ns/1ps
// ddr_rd_burst_sched: shares one DDR read port between NUM_CH video line
// requesters. It uses round-robin grants and keeps one burst outstanding at
// a time. Each granted line is issued as BURSTS_PER_LINE back-to-back bursts.
// Optional build macro: SCHED_TIMEOUT_EN adds a WAIT_DONE watchdog that
// abandons a stuck line and raises a sticky timeout_err.
module ddr_rd_burst_sched #(
    parameter int NUM_CH          = 2,
    parameter int AXI4_ADDR_WIDTH = 32,
    parameter int V_DISP          = 1080,
    parameter int LINE_BYTES      = 7680,
    parameter int BURSTS_PER_LINE = 2,
    parameter int BURST_BEATS     = 240,
    parameter int TIMEOUT         = 4096
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic [NUM_CH-1:0]                 req_valid,
    input  logic [NUM_CH-1:0]                 req_sof,
    output logic [NUM_CH-1:0]                 req_ready,
    input  logic [NUM_CH*AXI4_ADDR_WIDTH-1:0] ch_base_addr,
    output logic                              burst_valid,
    input  logic                              burst_ready,
    output logic [AXI4_ADDR_WIDTH-1:0]        burst_addr,
    output logic [7:0]                        burst_len,
    output logic [1:0]                        burst_ch,
    input  logic                              burst_done,
    output logic                              busy,
    output logic                              timeout_err
);
    localparam int AW = AXI4_ADDR_WIDTH;
    localparam int LW = (V_DISP > 1) ? $clog2(V_DISP) : 1;
    localparam logic [AW-1:0] LINE_BYTES_A  = AW'(LINE_BYTES);
    localparam logic [AW-1:0] BURST_BYTES_A = AW'(BURST_BEATS * 16);
    localparam logic [1:0]    LAST_BURST    = 2'(BURSTS_PER_LINE - 1);
    localparam logic [LW-1:0] LAST_LINE     = LW'(V_DISP - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t            state_reg, state_next;
    logic [1:0]        last_grant_reg;
    logic [1:0]        burst_idx_reg;
    logic [AW-1:0]     burst_addr_reg;
    logic [1:0]        burst_ch_reg;
    logic [NUM_CH*LW-1:0] line_cnt_flat;

    logic              grant_found;
    logic [1:0]        grant_ch;
    logic [1:0]        cand;
    logic              grant_fire;
    logic [3:0]        req_pad;
    logic [3:0]        sof_pad;
    logic [LW-1:0]     sel_line;
    logic [AW-1:0]     sel_base;
    logic              done_more;

`ifdef SCHED_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    logic [WDW-1:0]    wd_cnt_reg;
    logic              timeout_err_reg;
    logic              wd_fire;
`endif

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        req_pad     = 4'(req_valid);
        grant_found = 1'b0;
        grant_ch    = 2'd0;
        cand        = 2'd0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = 2'((int'(last_grant_reg) + k) % NUM_CH);
            if (!grant_found && req_pad[cand]) begin
                grant_found = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    assign grant_fire = (state_reg == IDLE) && grant_found;

    // Pick base address and line index of the channel being granted;
    // a start-of-frame request always starts at line 0.
    always_comb begin
        sof_pad  = 4'(req_sof);
        sel_base = '0;
        sel_line = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_ch == 2'(c)) begin
                sel_base = ch_base_addr[c*AW +: AW];
                sel_line = line_cnt_flat[c*LW +: LW];
            end
        end
        if (sof_pad[grant_ch]) sel_line = '0;
    end

    // Per-channel line counters and grant pulses.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [LW-1:0] line_cnt_reg;

        // Advance this channel's line counter on its grant, wrapping at frame end.
        always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
            if (!M_AXI_ARESETN)
                line_cnt_reg <= '0;
            else if (grant_fire && grant_ch == 2'(gi))
                line_cnt_reg <= (sel_line == LAST_LINE) ? '0 : sel_line + LW'(1);
        end

        assign line_cnt_flat[gi*LW +: LW] = line_cnt_reg;
        // Reset gating keeps req_ready low while reset is held, because IDLE is the reset state.
        assign req_ready[gi] = grant_fire && (grant_ch == 2'(gi)) && M_AXI_ARESETN;
    end

    // State register.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) state_reg <= IDLE;
        else                state_reg <= state_next;
    end

    // Next-state logic: one burst in flight, BURSTS_PER_LINE bursts per line.
    always_comb begin
        state_next = state_reg;
        done_more  = 1'b0;
`ifdef SCHED_TIMEOUT_EN
        wd_fire    = 1'b0;
`endif
        case (state_reg)
            IDLE:      if (grant_found) state_next = ISSUE;
            ISSUE:     if (burst_ready) state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (burst_done) begin
                    if (burst_idx_reg < LAST_BURST) begin
                        done_more  = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
`ifdef SCHED_TIMEOUT_EN
                else if (wd_cnt_reg == WD_LAST) begin
                    wd_fire    = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            default:   state_next = IDLE;
        endcase
    end

    // Burst command datapath: address is formed on grant, then stepped per burst.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            last_grant_reg <= 2'(NUM_CH - 1);
            burst_idx_reg  <= 2'd0;
            burst_addr_reg <= '0;
            burst_ch_reg   <= 2'd0;
        end else if (grant_fire) begin
            last_grant_reg <= grant_ch;
            burst_ch_reg   <= grant_ch;
            burst_idx_reg  <= 2'd0;
            burst_addr_reg <= sel_base + AW'(sel_line) * LINE_BYTES_A;
        end else if (done_more) begin
            burst_idx_reg  <= burst_idx_reg + 2'd1;
            burst_addr_reg <= burst_addr_reg + BURST_BYTES_A;
        end
    end

`ifdef SCHED_TIMEOUT_EN
    // Watchdog: counts WAIT_DONE cycles from zero on each entry; sticky error flag.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (state_reg == ISSUE && burst_ready) wd_cnt_reg <= '0;
            else if (state_reg == WAIT_DONE)       wd_cnt_reg <= wd_cnt_reg + WDW'(1);
            if (wd_fire) timeout_err_reg <= 1'b1;
        end
    end
    assign timeout_err = timeout_err_reg;
`else
    assign timeout_err = 1'b0;
`endif

    assign burst_valid = (state_reg == ISSUE);
    assign busy        = (state_reg != IDLE);
    assign burst_addr  = burst_addr_reg;
    assign burst_len   = 8'(BURST_BEATS - 1);
    assign burst_ch    = burst_ch_reg;

endmodule

// File: tb/tb_ddr_rd_burst_sched.sv
`timescale 1ns/1ps
// Directed bench for ddr_rd_burst_sched (2 channels, 2 bursts/line, TIMEOUT=16).
module tb_ddr_rd_burst_sched;
    localparam logic [31:0] BASE0 = 32'h1000_0000;
    localparam logic [31:0] BASE1 = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_sof = 2'b00;
    logic [1:0]  req_ready;
    logic [63:0] ch_base_addr = {BASE1, BASE0};
    logic        burst_valid;
    logic        burst_ready = 1'b0;
    logic [31:0] burst_addr;
    logic [7:0]  burst_len;
    logic [1:0]  burst_ch;
    logic        burst_done = 1'b0;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    ddr_rd_burst_sched #(
        .NUM_CH(2), .AXI4_ADDR_WIDTH(32), .V_DISP(1080), .LINE_BYTES(7680),
        .BURSTS_PER_LINE(2), .BURST_BEATS(240), .TIMEOUT(16)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .req_valid(req_valid), .req_sof(req_sof), .req_ready(req_ready),
        .ch_base_addr(ch_base_addr),
        .burst_valid(burst_valid), .burst_ready(burst_ready),
        .burst_addr(burst_addr), .burst_len(burst_len), .burst_ch(burst_ch),
        .burst_done(burst_done), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "global timeout");
    end

    function automatic logic [31:0] line_addr(input logic [31:0] base, input int line);
        return base + 32'(line) * 32'd7680;
    endfunction

    // Called at the negedge one cycle after a grant: checks/stalls the first burst,
    // then walks both bursts of the line to completion.
    task automatic do_bursts(input int ch, input logic [31:0] a0, input int stall, input string tag);
        logic [1:0] ech;
        ech = 2'(ch);
        for (int s = 0; s <= stall; s++) begin
            checks++; if (burst_valid !== 1'b1) begin errors++; $display("FAIL %s b0_valid cyc%0d: got %b want 1", tag, s, burst_valid); end
            checks++; if (burst_addr !== a0) begin errors++; $display("FAIL %s b0_addr cyc%0d: got %h want %h", tag, s, burst_addr, a0); end
            checks++; if (burst_len !== 8'd239) begin errors++; $display("FAIL %s b0_len cyc%0d: got %0d want 239", tag, s, burst_len); end
            checks++; if (burst_ch !== ech) begin errors++; $display("FAIL %s b0_ch cyc%0d: got %0d want %0d", tag, s, burst_ch, ech); end
            if (s < stall) begin
                burst_done = (s == 1);
                @(negedge clk);
            end
        end
        burst_done = 1'b0; burst_ready = 1'b1;
        @(negedge clk);
        burst_ready = 1'b0;
        checks++; if (burst_valid !== 1'b0) begin errors++; $display("FAIL %s wait_valid: got %b want 0", tag, burst_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s wait_busy: got %b want 1", tag, busy); end
        burst_done = 1'b1;
        @(negedge clk);
        burst_done = 1'b0;
        checks++; if (burst_valid !== 1'b1) begin errors++; $display("FAIL %s b1_valid: got %b want 1", tag, burst_valid); end
        checks++; if (burst_addr !== a0 + 32'd3840) begin errors++; $display("FAIL %s b1_addr: got %h want %h", tag, burst_addr, a0 + 32'd3840); end
        burst_ready = 1'b1;
        @(negedge clk);
        burst_ready = 1'b0; burst_done = 1'b1;
        @(negedge clk);
        burst_done = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s end_busy: got %b want 0", tag, busy); end
        checks++; if (burst_ch !== ech) begin errors++; $display("FAIL %s end_ch: got %0d want %0d", tag, burst_ch, ech); end
    endtask

    // Raise a single request while idle and check the grant pulse.
    task automatic grant(input int ch, input logic sof, input string tag);
        logic [1:0] m;
        m = 2'(1 << ch);
        req_valid = req_valid | m;
        req_sof   = sof ? (req_sof | m) : (req_sof & ~m);
        #1;
        checks++; if (req_ready !== m) begin errors++; $display("FAIL %s req_ready: got %b want %b", tag, req_ready, m); end
        @(negedge clk);
        req_valid = req_valid & ~m;
        req_sof   = req_sof & ~m;
    endtask

    task automatic serve_line(input int ch, input logic sof, input logic [31:0] a0, input string tag);
        grant(ch, sof, tag);
        do_bursts(ch, a0, 0, tag);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b11;
        #2;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst req_ready: got %b want 00", req_ready); end
        checks++; if (burst_valid !== 1'b0) begin errors++; $display("FAIL rst burst_valid: got %b want 0", burst_valid); end
        checks++; if (burst_addr !== 32'h0) begin errors++; $display("FAIL rst burst_addr: got %h want 0", burst_addr); end
        checks++; if (burst_len !== 8'd239) begin errors++; $display("FAIL rst burst_len: got %0d want 239", burst_len); end
        checks++; if (burst_ch !== 2'd0) begin errors++; $display("FAIL rst burst_ch: got %0d want 0", burst_ch); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst busy: got %b want 0", busy); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst timeout_err: got %b want 0", timeout_err); end
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_ch0();
        serve_line(0, 1'b1, BASE0, "single");
    endtask

    task automatic test_round_robin();
        int ch;
        pulse_reset();
        req_valid = 2'b11; req_sof = 2'b00;
        for (int i = 0; i < 4; i++) begin
            ch = i % 2;
            #1;
            checks++; if (req_ready !== 2'(1 << ch)) begin errors++; $display("FAIL rr grant%0d: got %b want %b", i, req_ready, 2'(1 << ch)); end
            @(negedge clk);
            do_bursts(ch, line_addr(ch == 0 ? BASE0 : BASE1, i / 2), 0, "rr");
        end
        req_valid = 2'b00;
    endtask

    task automatic test_line_wrap();
        serve_line(1, 1'b1, BASE1, "wrap_sof");
        for (int ln = 1; ln <= 1080; ln++)
            serve_line(1, 1'b0, line_addr(BASE1, ln % 1080), (ln >= 1079) ? "wrap_edge" : "wrap");
    endtask

    task automatic test_stall();
        grant(0, 1'b1, "stall");
        do_bursts(0, BASE0, 10, "stall");
    endtask

    task automatic test_reset_mid_burst();
        grant(1, 1'b1, "mid");
        burst_ready = 1'b1;
        @(negedge clk);
        burst_ready = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid pre_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (burst_valid !== 1'b0) begin errors++; $display("FAIL mid burst_valid: got %b want 0", burst_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid busy: got %b want 0", busy); end
        checks++; if (burst_addr !== 32'h0) begin errors++; $display("FAIL mid burst_addr: got %h want 0", burst_addr); end
        checks++; if (burst_ch !== 2'd0) begin errors++; $display("FAIL mid burst_ch: got %0d want 0", burst_ch); end
        checks++; if (burst_len !== 8'd239) begin errors++; $display("FAIL mid burst_len: got %0d want 239", burst_len); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            burst_done = (c == 2);
            @(negedge clk);
            checks++; if (burst_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid post_idle cyc%0d: got valid=%b busy=%b want 0 0", c, burst_valid, busy); end
        end
        burst_done = 1'b0;
        req_valid = 2'b11; req_sof = 2'b00;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid first_grant: got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b10;
        do_bursts(0, BASE0, 0, "mid_ch0");
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL mid second_grant: got %b want 10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        do_bursts(1, BASE1, 0, "mid_ch1");
    endtask

    task automatic test_watchdog();
        grant(0, 1'b1, "wd");
        burst_ready = 1'b1;
        @(negedge clk);
        burst_ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 15) begin
                checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wd early: got err=%b busy=%b want 0 1", timeout_err, busy); end
            end
`ifdef SCHED_TIMEOUT_EN
            if (k == 16) begin
                checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wd fire: got err=%b busy=%b want 1 0", timeout_err, busy); end
            end
`else
            if (k == 20) begin
                checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wd hold: got err=%b busy=%b want 0 1", timeout_err, busy); end
            end
`endif
        end
`ifndef SCHED_TIMEOUT_EN
        burst_done = 1'b1;
        @(negedge clk);
        burst_done = 1'b0;
        checks++; if (burst_addr !== BASE0 + 32'd3840) begin errors++; $display("FAIL wd b1_addr: got %h want %h", burst_addr, BASE0 + 32'd3840); end
        burst_ready = 1'b1;
        @(negedge clk);
        burst_ready = 1'b0; burst_done = 1'b1;
        @(negedge clk);
        burst_done = 1'b0;
`endif
        serve_line(1, 1'b1, BASE1, "wd_next");
`ifdef SCHED_TIMEOUT_EN
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd sticky: got %b want 1", timeout_err); end
`else
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd tied: got %b want 0", timeout_err); end
`endif
    endtask

    initial begin
        test_reset();
        $display("test_reset done: %0d checks, %0d errors", checks, errors);
        test_single_ch0();
        $display("test_single_ch0 done: %0d checks, %0d errors", checks, errors);
        test_round_robin();
        $display("test_round_robin done: %0d checks, %0d errors", checks, errors);
        test_line_wrap();
        $display("test_line_wrap done: %0d checks, %0d errors", checks, errors);
        test_stall();
        $display("test_stall done: %0d checks, %0d errors", checks, errors);
        test_reset_mid_burst();
        $display("test_reset_mid_burst done: %0d checks, %0d errors", checks, errors);
        test_watchdog();
        $display("test_watchdog done: %0d checks, %0d errors", checks, errors);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
